// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: streams operands LSB-first through a single
// full-adder cell, then presents sum, carry-out and signed overflow with a done pulse.

module fa (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, result;
  logic [CW-1:0]    cnt;
  logic             carry, carry_msb;
  logic             fa_sum, fa_cout;
  logic             last_bit, load, shift_en, finish;

  fa u_fa (
    .cout (fa_cout),
    .sum  (fa_sum),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    load     = (state == IDLE) && start;
    shift_en = (state == SHIFT);
    finish   = (state == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; carry_msb relies on reading carry before its update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      result    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        a_sr  <= a;
        b_sr  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
      end else if (shift_en) begin
        result <= {fa_sum, result[WIDTH-1:1]};
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= fa_cout;
        cnt    <= cnt + CW'(1);
        // Carry into the MSB is the carry present while the MSB is being added.
        if (last_bit) carry_msb <= carry;
      end
      if (finish) begin
        sum      <= result;
        cout     <= carry;
        overflow <= carry_msb ^ carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus exhaustive and random
// operations checked against an arithmetic reference model, with cycle-exact busy/done timing.

module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;
  logic         prev_ovf  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic; overflow from the signed result range.
  function automatic logic [W+1:0] golden(input int ua, input int ub, input logic c, input logic s);
    int full, sa, sb, sr, md, half;
    logic o, co;
    logic [W-1:0] r;
    md   = 1 << W;
    half = 1 << (W - 1);
    sa = (ua >= half) ? ua - md : ua;
    sb = (ub >= half) ? ub - md : ub;
    if (s) begin
      full = ua + (md - 1 - ub) + 1;
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(c);
      sr   = sa + sb + int'(c);
    end
    o  = (sr >= half) || (sr < -half);
    co = (full >= md);
    r  = W'(full);
    return {o, co, r};
  endfunction

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== prev_sum || cout !== prev_cout || overflow !== prev_ovf) begin
      n_bad++;
      $display("FAIL %s: busy=%b done=%b sum=%0d cout=%b ovf=%b, expected 0/0 sum=%0d cout=%b ovf=%b",
               tag, busy, done, sum, cout, overflow, prev_sum, prev_cout, prev_ovf);
    end
  endtask

  // Called with the DUT idle (or in its done cycle); returns in the done cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tcin,
                       input logic tsub, input bit noise, input string tag);
    logic [W+1:0] exp;
    exp   = golden(int'(ta), int'(tbv), tcin, tsub);
    a     = ta;
    b     = tbv;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    tick();
    for (int k = 0; k <= W; k++) begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s timing edge %0d: busy=%b done=%b, expected busy=1 done=0", tag, k, busy, done);
      end
      n_cmp++;
      if (sum !== prev_sum || cout !== prev_cout || overflow !== prev_ovf) begin
        n_bad++;
        $display("FAIL %s hold edge %0d: sum=%0d cout=%b ovf=%b, expected sum=%0d cout=%b ovf=%b",
                 tag, k, sum, cout, overflow, prev_sum, prev_cout, prev_ovf);
      end
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      start = noise;
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done edge: busy=%b done=%b, expected busy=0 done=1", tag, busy, done);
    end
    n_cmp++;
    if (sum !== exp[W-1:0] || cout !== exp[W] || overflow !== exp[W+1]) begin
      n_bad++;
      $display("FAIL %s result a=%0d b=%0d cin=%b sub=%b: sum=%0d cout=%b ovf=%b, expected sum=%0d cout=%b ovf=%b",
               tag, ta, tbv, tcin, tsub, sum, cout, overflow, exp[W-1:0], exp[W], exp[W+1]);
    end
    start     = 1'b0;
    prev_sum  = exp[W-1:0];
    prev_cout = exp[W];
    prev_ovf  = exp[W+1];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b sum=%0d cout=%b ovf=%b, expected all 0",
               busy, done, sum, cout, overflow);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_outputs("post_reset_idle");
    end
  endtask

  task automatic test_add();
    do_op(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, "add_3_5");
    tick();
    check_idle_outputs("add_3_5_after");
    do_op(4'd15, 4'd1, 1'b0, 1'b0, 1'b0, "add_15_1");
    tick();
    do_op(4'd6, 4'd6, 1'b1, 1'b0, 1'b0, "add_6_6_c1");
    tick();
  endtask

  task automatic test_sub();
    do_op(4'd7, 4'd2, 1'b0, 1'b1, 1'b0, "sub_7_2");
    tick();
    do_op(4'd2, 4'd7, 1'b1, 1'b1, 1'b0, "sub_2_7_cin_ignored");
    tick();
  endtask

  task automatic test_start_while_busy();
    do_op(4'd9, 4'd12, 1'b1, 1'b0, 1'b1, "start_while_busy");
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check_idle_outputs("single_done");
    end
  endtask

  task automatic test_reset_abort();
    a     = 4'd5;
    b     = 4'd4;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL async_abort: busy=%b done=%b sum=%0d cout=%b ovf=%b, expected all 0",
               busy, done, sum, cout, overflow);
    end
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check_idle_outputs("no_done_after_abort");
    end
    do_op(4'd10, 4'd11, 1'b1, 1'b0, 1'b0, "after_abort");
    tick();
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < (1 << W); x++)
          for (int y = 0; y < (1 << W); y++)
            do_op(W'(x), W'(y), 1'(c), 1'(s), 1'b0, "exhaustive");
    tick();
    check_idle_outputs("exhaustive_tail");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
